// File: rtl/regfile_mp_if.sv
// Register-file bus: two writeback ports, NR packed read ports, issue tracking and init status.
// The master side is the pipeline; the slave side is regfile_mp.
interface regfile_mp_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2
);
  logic             we0;
  logic [AW-1:0]    waddr0;
  logic [DW-1:0]    wdata0;
  logic             we1;
  logic [AW-1:0]    waddr1;
  logic [DW-1:0]    wdata1;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             issue_en;
  logic [AW-1:0]    issue_rd;
  logic             ready;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, issue_en, issue_rd,
    input  rdata, rbusy, ready
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, issue_en, issue_rd,
    output rdata, rbusy, ready
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NR bypassed read ports, pending-write scoreboard and a post-reset init sweep.
// Define REGFILE_SP_INIT_EN to have the sweep load SP_RESET_VAL into register SP_IDX.
module regfile_mp #(
  parameter int            DW           = 32,
  parameter int            AW           = 5,
  parameter int            NR           = 2,
  parameter int            SP_IDX       = 2,
  parameter logic [DW-1:0] SP_RESET_VAL = DW'(32'h500)
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave io_rf
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {INIT, RUN} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [AW-1:0]    r_cnt;
  logic [DW-1:0]    r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busyNext;
  logic [DW-1:0]    w_initVal;
  logic [AW-1:0]    w_raddr [NR];
  logic             w_run;

  assign w_run       = (r_state == RUN);
  assign io_rf.ready = w_run;

  always_ff @(posedge clk) begin
    if (rst) r_state <= INIT;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      INIT:    if (r_cnt == AW'(DEPTH - 1)) w_nextState = RUN;
      RUN:     w_nextState = RUN;
      default: w_nextState = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                 r_cnt <= '0;
    else if (r_state == INIT) r_cnt <= r_cnt + AW'(1);
  end

`ifdef REGFILE_SP_INIT_EN
  assign w_initVal = (r_cnt == AW'(SP_IDX)) ? SP_RESET_VAL : '0;
`else
  assign w_initVal = '0;
`endif

  // Storage has no reset of its own: the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == INIT) begin
        r_regs[r_cnt] <= w_initVal;
      end else begin
        if (io_rf.we0 && io_rf.waddr0 != '0) r_regs[io_rf.waddr0] <= io_rf.wdata0;
        if (io_rf.we1 && io_rf.waddr1 != '0) r_regs[io_rf.waddr1] <= io_rf.wdata1;
      end
    end
  end

  // Clear on write, then set on issue, so a same-cycle issue keeps the register busy.
  always_comb begin
    w_busyNext = r_busy;
    for (int i = 1; i < DEPTH; i++) begin
      if ((io_rf.we0 && io_rf.waddr0 == AW'(i)) || (io_rf.we1 && io_rf.waddr1 == AW'(i)))
        w_busyNext[i] = 1'b0;
      if (io_rf.issue_en && io_rf.issue_rd == AW'(i))
        w_busyNext[i] = 1'b1;
    end
    w_busyNext[0] = 1'b0;
    if (!w_run) w_busyNext = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busyNext;
  end

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      w_raddr[k] = io_rf.raddr[k*AW +: AW];
    end
  end

  always_comb begin
    io_rf.rdata = '0;
    io_rf.rbusy = '0;
    for (int k = 0; k < NR; k++) begin
      if (w_run && w_raddr[k] != '0) begin
        if (io_rf.we1 && io_rf.waddr1 == w_raddr[k])
          io_rf.rdata[k*DW +: DW] = io_rf.wdata1;
        else if (io_rf.we0 && io_rf.waddr0 == w_raddr[k])
          io_rf.rdata[k*DW +: DW] = io_rf.wdata0;
        else
          io_rf.rdata[k*DW +: DW] = r_regs[w_raddr[k]];
        io_rf.rbusy[k] = w_busyNext[w_raddr[k]];
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed scenarios plus random traffic against an array-based model.
// Expected outputs are queued per cycle and checked by an independent monitor at the falling edge.
module tb_regfile_mp;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_mp_if #(.DW(DW), .AW(AW), .NR(NR)) rf ();

  regfile_mp #(
    .DW(DW), .AW(AW), .NR(NR), .SP_IDX(2), .SP_RESET_VAL(32'h500)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .io_rf(rf)
  );

  typedef struct {
    bit            rst;
    bit            we0;
    logic [AW-1:0] waddr0;
    logic [DW-1:0] wdata0;
    bit            we1;
    logic [AW-1:0] waddr1;
    logic [DW-1:0] wdata1;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    bit            issueEn;
    logic [AW-1:0] issueRd;
  } stim_t;

  typedef struct {
    int               id;
    logic             ready;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   cycleId = 0;

  // Reference model: register contents, pending bits, and cycles left until ready.
  logic [DW-1:0] mMem [DEPTH];
  bit            mBusy [DEPTH];
  int            mInitLeft = DEPTH;
  bit            mValid = 1'b0;

  function automatic logic [DW-1:0] initValue(int a);
`ifdef REGFILE_SP_INIT_EN
    return (a == 2) ? 32'h500 : 32'h0;
`else
    return (a == 2) ? 32'h0 : 32'h0;
`endif
  endfunction

  function automatic stim_t idleStim(int ra0, int ra1);
    stim_t s;
    s.rst = 0; s.we0 = 0; s.waddr0 = '0; s.wdata0 = '0;
    s.we1 = 0; s.waddr1 = '0; s.wdata1 = '0;
    s.ra0 = AW'(ra0); s.ra1 = AW'(ra1);
    s.issueEn = 0; s.issueRd = '0;
    return s;
  endfunction

  function automatic void modelRead(input stim_t s, input logic [AW-1:0] a,
                                    output logic [DW-1:0] d, output logic b);
    int ai;
    ai = int'(a);
    d = '0;
    b = 1'b0;
    if (mInitLeft == 0 && ai != 0) begin
      if (s.we1 && s.waddr1 == a)      d = s.wdata1;
      else if (s.we0 && s.waddr0 == a) d = s.wdata0;
      else                             d = mMem[ai];
      if (s.issueEn && s.issueRd == a)                               b = 1'b1;
      else if ((s.we0 && s.waddr0 == a) || (s.we1 && s.waddr1 == a)) b = 1'b0;
      else                                                           b = mBusy[ai];
    end
  endfunction

  task automatic applyStimulus(input stim_t s);
    exp_t          e;
    logic [DW-1:0] d;
    logic          b;
    rst         = s.rst;
    rf.we0      = s.we0;  rf.waddr0 = s.waddr0; rf.wdata0 = s.wdata0;
    rf.we1      = s.we1;  rf.waddr1 = s.waddr1; rf.wdata1 = s.wdata1;
    rf.raddr    = {s.ra1, s.ra0};
    rf.issue_en = s.issueEn;
    rf.issue_rd = s.issueRd;
    if (mValid) begin
      e.id    = cycleId;
      e.ready = (mInitLeft == 0);
      modelRead(s, s.ra0, d, b);
      e.rdata[DW-1:0] = d;  e.rbusy[0] = b;
      modelRead(s, s.ra1, d, b);
      e.rdata[2*DW-1:DW] = d;  e.rbusy[1] = b;
      expQ.push_back(e);
    end
    @(posedge clk);
    if (s.rst) begin
      mValid    = 1'b1;
      mInitLeft = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
        mMem[i]  = initValue(i);
        mBusy[i] = 1'b0;
      end
    end else if (mInitLeft > 0) begin
      mInitLeft--;
    end else begin
      if (s.we0 && s.waddr0 != '0) mMem[int'(s.waddr0)] = s.wdata0;
      if (s.we1 && s.waddr1 != '0) mMem[int'(s.waddr1)] = s.wdata1;
      if (s.we0) mBusy[int'(s.waddr0)] = 1'b0;
      if (s.we1) mBusy[int'(s.waddr1)] = 1'b0;
      if (s.issueEn && s.issueRd != '0) mBusy[int'(s.issueRd)] = 1'b1;
    end
    cycleId++;
    #1;
  endtask

  task automatic idle(int n, int ra0, int ra1);
    for (int i = 0; i < n; i++) applyStimulus(idleStim(ra0, ra1));
  endtask

  task automatic checkOutput(input exp_t e);
    nChecks++;
    if (rf.ready !== e.ready) begin
      nFails++;
      $display("[TB] FAIL ready cycle=%0d actual=%b required=%b", e.id, rf.ready, e.ready);
    end
    for (int k = 0; k < NR; k++) begin
      nChecks++;
      if (rf.rdata[k*DW +: DW] !== e.rdata[k*DW +: DW]) begin
        nFails++;
        $display("[TB] FAIL rdata%0d cycle=%0d actual=%h required=%h",
                 k, e.id, rf.rdata[k*DW +: DW], e.rdata[k*DW +: DW]);
      end
      nChecks++;
      if (rf.rbusy[k] !== e.rbusy[k]) begin
        nFails++;
        $display("[TB] FAIL rbusy%0d cycle=%0d actual=%b required=%b",
                 k, e.id, rf.rbusy[k], e.rbusy[k]);
      end
    end
  endtask

  // Monitor: consumes one queued expectation whenever the bench has issued one.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    stim_t s;
    s = idleStim(0, 0);
    s.rst = 1;
    applyStimulus(s);
    applyStimulus(s);

    $display("[TB] init sweep");
    idle(DEPTH, 2, 0);
    for (int a = 0; a < DEPTH; a += 2) idle(1, a, a + 1);

    $display("[TB] basic write/read");
    s = idleStim(0, 0);
    s.we0 = 1; s.waddr0 = 5; s.wdata0 = 32'hDEADBEEF;
    applyStimulus(s);
    idle(1, 5, 0);
    s = idleStim(0, 5);
    s.we0 = 1; s.waddr0 = 0; s.wdata0 = 32'hCAFEF00D;
    applyStimulus(s);
    idle(1, 0, 5);

    $display("[TB] bypass and priority");
    s = idleStim(7, 7);
    s.we0 = 1; s.waddr0 = 7; s.wdata0 = 32'h11;
    s.we1 = 1; s.waddr1 = 7; s.wdata1 = 32'h22;
    applyStimulus(s);
    idle(1, 7, 7);

    $display("[TB] scoreboard");
    s = idleStim(9, 0);
    s.issueEn = 1; s.issueRd = 9;
    applyStimulus(s);
    idle(1, 0, 9);
    s = idleStim(9, 9);
    s.we1 = 1; s.waddr1 = 9; s.wdata1 = 32'h99;
    applyStimulus(s);
    idle(1, 9, 0);
    s = idleStim(9, 0);
    s.issueEn = 1; s.issueRd = 9;
    s.we0 = 1; s.waddr0 = 9; s.wdata0 = 32'h123;
    applyStimulus(s);
    idle(1, 0, 9);
    s = idleStim(0, 0);
    s.issueEn = 1; s.issueRd = 0;
    applyStimulus(s);

    $display("[TB] reset mid-operation");
    s = idleStim(3, 0);
    s.we0 = 1; s.waddr0 = 3; s.wdata0 = 32'h55;
    s.issueEn = 1; s.issueRd = 3;
    applyStimulus(s);
    idle(1, 3, 3);
    s = idleStim(3, 3);
    s.rst = 1;
    applyStimulus(s);
    for (int i = 0; i < DEPTH; i++) begin
      s = idleStim(3, 2);
      s.we0 = 1; s.waddr0 = 3; s.wdata0 = 32'h77;
      s.issueEn = 1; s.issueRd = 3;
      applyStimulus(s);
    end
    idle(2, 3, 2);

    $display("[TB] reset during init");
    s = idleStim(1, 2);
    s.rst = 1;
    applyStimulus(s);
    idle(10, 1, 2);
    applyStimulus(s);
    idle(DEPTH + 2, 2, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      s.rst     = ($urandom_range(0, 299) == 0);
      s.we0     = $urandom_range(0, 1);
      s.waddr0  = AW'($urandom_range(0, 7));
      s.wdata0  = $urandom;
      s.we1     = $urandom_range(0, 1);
      s.waddr1  = AW'($urandom_range(0, 7));
      s.wdata1  = $urandom;
      s.ra0     = AW'($urandom_range(0, 7));
      s.ra1     = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                              : AW'($urandom_range(0, 7));
      s.issueEn = ($urandom_range(0, 9) < 3);
      s.issueRd = AW'($urandom_range(0, 7));
      applyStimulus(s);
    end
    idle(2, 0, 0);

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL drain actual=%0d pending required=0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
